// File: rtl/bsg_wormhole_concentrator_out.sv
// Purpose : split one concentrated wormhole link into num_out_p links, steering each packet by its header cid.
// Latency : 1 cycle from input acceptance to output valid; 1 flit/cycle sustained, no bubble between packets.
// Backpr. : 2-entry input buffer; a stalled destination holds the buffer head, so input ready drops once 2 flits wait.
//
// Ports:
//   clk_i, reset_i                      - clock, synchronous active-high reset
//   concentrated_link_v_i/_data_i       - input flit valid / data
//   concentrated_link_ready_and_rev_o   - input ready (buffer not full, low during reset)
//   links_v_o[num_out_p]                - per-output valid, at most one bit set
//   links_data_o[num_out_p*flit]        - buffer head replicated on every output
//   links_ready_and_rev_i[num_out_p]    - per-output ready

// Purpose : two-entry flit buffer feeding the router.
// Latency : write in cycle t is visible at the head in cycle t+1.
// Backpr. : enq_rdy is low while both entries are occupied.
module bsg_wormhole_concentrator_out_fifo #(
    parameter int width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               enq_vld,
    input  logic [width_p-1:0] enq_dat,
    output logic               enq_rdy,
    output logic               deq_vld,
    output logic [width_p-1:0] deq_dat,
    input  logic               deq_yumi
);
    logic [width_p-1:0] mem_r [2];
    logic               wptr_r;
    logic               rptr_r;
    logic [1:0]         cnt_r;
    logic               enq;
    logic               deq;

    assign enq_rdy = (cnt_r != 2'd2);
    assign deq_vld = (cnt_r != 2'd0);
    assign deq_dat = mem_r[rptr_r];
    assign enq     = enq_vld & enq_rdy;
    assign deq     = deq_yumi & deq_vld;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_r <= 1'b0;
            rptr_r <= 1'b0;
            cnt_r  <= 2'd0;
        end else begin
            if (enq) wptr_r <= ~wptr_r;
            if (deq) rptr_r <= ~rptr_r;
            cnt_r <= cnt_r + 2'(enq) - 2'(deq);
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (enq) mem_r[wptr_r] <= enq_dat;
    end
endmodule

module bsg_wormhole_concentrator_out #(
    // Field-width defaults are nominal; instantiations are expected to set all of them.
    parameter int flit_width_p = 16,
    parameter int len_width_p  = 4,
    parameter int cid_width_p  = 2,
    parameter int cord_width_p = 4,
    parameter int num_out_p    = 1,
    parameter int debug_lp     = 0
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              concentrated_link_v_i,
    input  logic [flit_width_p-1:0]           concentrated_link_data_i,
    output logic                              concentrated_link_ready_and_rev_o,
    output logic [num_out_p-1:0]              links_v_o,
    output logic [num_out_p*flit_width_p-1:0] links_data_o,
    input  logic [num_out_p-1:0]              links_ready_and_rev_i
);
    // cid may be zero-width for a single output; keep a 1-bit destination then.
    localparam int cid_w_lp   = (cid_width_p > 0) ? cid_width_p : 1;
    localparam int cid_lsb_lp = cord_width_p + len_width_p;

    typedef enum logic {HDR, BODY} state_e;

    logic                    fifo_vld;
    logic                    fifo_rdy;
    logic                    fifo_yumi;
    logic [flit_width_p-1:0] fifo_dat;

    state_e                  state_r, state_n;
    logic [len_width_p-1:0]  cnt_r, cnt_n;
    logic [cid_w_lp-1:0]     dest_r, dest_n;

    logic [len_width_p-1:0]  hdr_len;
    logic [cid_w_lp-1:0]     hdr_cid;
    logic [cid_w_lp-1:0]     dest;
    logic [num_out_p-1:0]    dest_oh;
    logic                    dest_legal;
    logic                    dest_rdy;

    bsg_wormhole_concentrator_out_fifo #(
        .width_p (flit_width_p)
    ) u_fifo (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .enq_vld  (concentrated_link_v_i),
        .enq_dat  (concentrated_link_data_i),
        .enq_rdy  (fifo_rdy),
        .deq_vld  (fifo_vld),
        .deq_dat  (fifo_dat),
        .deq_yumi (fifo_yumi)
    );

    assign hdr_len = fifo_dat[cord_width_p +: len_width_p];

    generate
        if (cid_width_p == 0 || num_out_p == 1) begin : g_single_dest
            assign hdr_cid = '0;
        end else begin : g_cid_dest
            assign hdr_cid = fifo_dat[cid_lsb_lp +: cid_width_p];
        end
    endgenerate

    // Header flits route by their own cid; body flits follow the latched one.
    assign dest = (state_r == BODY) ? dest_r : hdr_cid;

    // One-hot decode; a cid beyond the last output decodes to all zeros,
    // which both suppresses valid and marks the packet for dropping.
    generate
        for (genvar d = 0; d < num_out_p; d++) begin : g_dec
            assign dest_oh[d] = (dest == cid_w_lp'(d));
        end
    endgenerate

    assign dest_legal = |dest_oh;
    assign dest_rdy   = |(dest_oh & links_ready_and_rev_i);

    // Illegal-cid flits drain at one per cycle regardless of output ready.
    assign fifo_yumi  = fifo_vld & (dest_legal ? dest_rdy : 1'b1);

    assign links_v_o    = (fifo_vld & ~reset_i) ? dest_oh : '0;
    assign links_data_o = {num_out_p{fifo_dat}};
    assign concentrated_link_ready_and_rev_o = fifo_rdy & ~reset_i;

    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        dest_n  = dest_r;
        if (fifo_yumi) begin
            unique case (state_r)
                HDR: begin
                    if (hdr_len != '0) begin
                        state_n = BODY;
                        cnt_n   = hdr_len;
                        dest_n  = hdr_cid;
                    end
                end
                BODY: begin
                    // cnt_r is at least 1 in BODY, so this never wraps.
                    cnt_n = cnt_r - len_width_p'(1);
                    if (cnt_r == len_width_p'(1)) state_n = HDR;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= HDR;
            cnt_r   <= '0;
            dest_r  <= '0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            dest_r  <= dest_n;
        end
    end

    generate
        if (debug_lp != 0) begin : g_debug
`ifndef SYNTHESIS
            always_ff @(posedge clk_i) begin
                if (!reset_i && fifo_yumi && state_r == HDR)
                    $display("%m: header cid=%0d len=%0d cord=%0h",
                             hdr_cid, hdr_len, fifo_dat[cord_width_p-1:0]);
            end
`endif
        end
    endgenerate
endmodule

// File: tb/tb_bsg_wormhole_concentrator_out.sv
module tb_bsg_wormhole_concentrator_out;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    // four-output instance
    logic        v4, irdy4;
    logic [15:0] d4;
    logic [3:0]  lv4, lr4;
    logic [63:0] ld4;
    // three-output instance (cid 3 is illegal)
    logic        v3, irdy3;
    logic [15:0] d3;
    logic [2:0]  lv3, lr3;
    logic [47:0] ld3;

    bsg_wormhole_concentrator_out #(
        .flit_width_p(16), .len_width_p(3), .cid_width_p(2),
        .cord_width_p(4), .num_out_p(4), .debug_lp(0)
    ) dut4 (
        .clk_i(clk), .reset_i(rst),
        .concentrated_link_v_i(v4), .concentrated_link_data_i(d4),
        .concentrated_link_ready_and_rev_o(irdy4),
        .links_v_o(lv4), .links_data_o(ld4), .links_ready_and_rev_i(lr4)
    );

    bsg_wormhole_concentrator_out #(
        .flit_width_p(16), .len_width_p(3), .cid_width_p(2),
        .cord_width_p(4), .num_out_p(3), .debug_lp(0)
    ) dut3 (
        .clk_i(clk), .reset_i(rst),
        .concentrated_link_v_i(v3), .concentrated_link_data_i(d3),
        .concentrated_link_ready_and_rev_o(irdy3),
        .links_v_o(lv3), .links_data_o(ld3), .links_ready_and_rev_i(lr3)
    );

    typedef struct {
        logic        sel3;
        logic        v;
        logic [15:0] dat;
        logic [3:0]  rdy;
        logic        exp_irdy;
        logic [3:0]  exp_lv;
        logic [15:0] exp_dat;
    } vec_t;

    typedef struct {
        logic [15:0] d;
        int          dest;
    } fl_t;

    int n_chk  = 0;
    int n_pass = 0;
    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // header: payload[15:9] cid[8:7] len[6:4] cord[3:0]
    function automatic logic [15:0] hf(int cid, int len, int pay);
        return {7'(pay), 2'(cid), 3'(len), 4'h5};
    endfunction

    function automatic logic [15:0] bf(int pay);
        return 16'(16'hB000 + pay);
    endfunction

    function automatic vec_t mk(logic s, logic v, logic [15:0] d, logic [3:0] r,
                                logic ei, logic [3:0] el, logic [15:0] ed);
        vec_t x;
        x.sel3 = s; x.v = v; x.dat = d; x.rdy = r;
        x.exp_irdy = ei; x.exp_lv = el; x.exp_dat = ed;
        return x;
    endfunction

    task automatic run_tbl(input string nm);
        logic [3:0]  lv;
        logic [63:0] ld;
        logic        ir;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].sel3) begin
                v3 = vecs[i].v; d3 = vecs[i].dat; lr3 = vecs[i].rdy[2:0];
                v4 = 1'b0; d4 = '0; lr4 = 4'hF;
            end else begin
                v4 = vecs[i].v; d4 = vecs[i].dat; lr4 = vecs[i].rdy;
                v3 = 1'b0; d3 = '0; lr3 = 3'h7;
            end
            @(negedge clk);
            if (vecs[i].sel3) begin
                lv = {1'b0, lv3}; ld = {16'h0, ld3}; ir = irdy3;
            end else begin
                lv = lv4; ld = ld4; ir = irdy4;
            end
            chk($sformatf("%s[%0d].in_ready", nm, i), 32'(ir), 32'(vecs[i].exp_irdy));
            chk($sformatf("%s[%0d].links_v", nm, i), 32'(lv), 32'(vecs[i].exp_lv));
            for (int d = 0; d < 4; d++)
                if (vecs[i].exp_lv[d])
                    chk($sformatf("%s[%0d].data%0d", nm, i, d), 32'(ld[d*16 +: 16]),
                        32'(vecs[i].exp_dat));
            @(posedge clk); #1;
        end
        vecs.delete();
    endtask

    initial begin
        logic [15:0] f[9];
        fl_t stim[$];
        fl_t expq[$];
        int  cyc;
        int  nflit;

        rst = 1'b1; v4 = 1'b0; d4 = '0; lr4 = '0; v3 = 1'b0; d3 = '0; lr3 = '0;

        // ---- reset state ----
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("reset[%0d].in_ready4", i), 32'(irdy4), 0);
            chk($sformatf("reset[%0d].links_v4", i), 32'(lv4), 0);
            chk($sformatf("reset[%0d].in_ready3", i), 32'(irdy3), 0);
            chk($sformatf("reset[%0d].links_v3", i), 32'(lv3), 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // ---- single flit, multi flit, back-to-back with zero bubble ----
        vecs.push_back(mk(0, 1, hf(2,0,1), 4'hF, 1, 4'b0000, 16'h0));
        vecs.push_back(mk(0, 1, hf(1,3,2), 4'hF, 1, 4'b0100, hf(2,0,1)));
        vecs.push_back(mk(0, 1, bf(3),     4'hF, 1, 4'b0010, hf(1,3,2)));
        vecs.push_back(mk(0, 1, bf(4),     4'hF, 1, 4'b0010, bf(3)));
        vecs.push_back(mk(0, 1, bf(5),     4'hF, 1, 4'b0010, bf(4)));
        vecs.push_back(mk(0, 1, hf(0,1,6), 4'hF, 1, 4'b0010, bf(5)));
        vecs.push_back(mk(0, 1, bf(7),     4'hF, 1, 4'b0001, hf(0,1,6)));
        vecs.push_back(mk(0, 1, hf(3,0,8), 4'hF, 1, 4'b0001, bf(7)));
        vecs.push_back(mk(0, 1, hf(0,2,9), 4'hF, 1, 4'b1000, hf(3,0,8)));
        vecs.push_back(mk(0, 1, bf(10),    4'hF, 1, 4'b0001, hf(0,2,9)));
        vecs.push_back(mk(0, 1, bf(11),    4'hF, 1, 4'b0001, bf(10)));
        vecs.push_back(mk(0, 0, 16'h0,     4'hF, 1, 4'b0001, bf(11)));
        vecs.push_back(mk(0, 0, 16'h0,     4'hF, 1, 4'b0000, 16'h0));
        run_tbl("basic");

        // ---- backpressure: output 1 stalls 5 cycles mid-packet ----
        vecs.push_back(mk(0, 1, hf(1,4,20), 4'hF,    1, 4'b0000, 16'h0));
        vecs.push_back(mk(0, 1, bf(21),     4'hF,    1, 4'b0010, hf(1,4,20)));
        vecs.push_back(mk(0, 1, bf(22),     4'b1101, 1, 4'b0010, bf(21)));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 1, bf(23), 4'b1101, 0, 4'b0010, bf(21)));
        vecs.push_back(mk(0, 1, bf(23),     4'hF,    0, 4'b0010, bf(21)));
        vecs.push_back(mk(0, 1, bf(23),     4'hF,    1, 4'b0010, bf(22)));
        vecs.push_back(mk(0, 1, bf(24),     4'hF,    1, 4'b0010, bf(23)));
        vecs.push_back(mk(0, 0, 16'h0,      4'hF,    1, 4'b0010, bf(24)));
        vecs.push_back(mk(0, 0, 16'h0,      4'hF,    1, 4'b0000, 16'h0));
        run_tbl("bp");

        // ---- illegal cid on 3-output instance, drained even with outputs not ready ----
        vecs.push_back(mk(1, 1, hf(3,2,30), 4'h0, 1, 4'b0000, 16'h0));
        vecs.push_back(mk(1, 1, bf(31),     4'h0, 1, 4'b0000, 16'h0));
        vecs.push_back(mk(1, 1, bf(32),     4'h0, 1, 4'b0000, 16'h0));
        vecs.push_back(mk(1, 1, hf(0,0,33), 4'h0, 1, 4'b0000, 16'h0));
        vecs.push_back(mk(1, 0, 16'h0,      4'h7, 1, 4'b0001, hf(0,0,33)));
        vecs.push_back(mk(1, 0, 16'h0,      4'h7, 1, 4'b0000, 16'h0));
        run_tbl("illegal");

        // ---- maximum len (7) gives 8 flits, then a header to another output ----
        f[0] = hf(0,7,50);
        for (int i = 1; i < 8; i++) f[i] = bf(50 + i);
        f[8] = hf(1,0,58);
        for (int i = 0; i <= 10; i++)
            vecs.push_back(mk(0, (i <= 8), (i <= 8) ? f[i] : 16'h0, 4'hF, 1,
                              (i == 0 || i == 10) ? 4'b0000 : ((i == 9) ? 4'b0010 : 4'b0001),
                              (i >= 1 && i <= 9) ? f[i-1] : 16'h0));
        run_tbl("maxlen");

        // ---- reset in the middle of a 5-flit packet ----
        v4 = 1'b1; d4 = hf(2,4,40); lr4 = 4'hF;
        @(posedge clk); #1;
        d4 = bf(41);
        @(posedge clk); #1;
        v4 = 1'b0;
        @(negedge clk);
        chk("midrst.pre_links_v", 32'(lv4), 32'h4);
        @(posedge clk); #1;
        rst = 1'b1; v4 = 1'b1; d4 = bf(42);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("midrst.rst%0d.links_v", i), 32'(lv4), 0);
            chk($sformatf("midrst.rst%0d.in_ready", i), 32'(irdy4), 0);
            @(posedge clk); #1;
        end
        rst = 1'b0; v4 = 1'b1; d4 = hf(3,0,43);
        @(negedge clk);
        chk("midrst.post_in_ready", 32'(irdy4), 1);
        chk("midrst.post_links_v0", 32'(lv4), 0);
        @(posedge clk); #1;
        v4 = 1'b0;
        @(negedge clk);
        chk("midrst.new_hdr_links_v", 32'(lv4), 32'h8);
        chk("midrst.new_hdr_data", 32'(ld4[48 +: 16]), 32'(hf(3,0,43)));
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst.idle_links_v", 32'(lv4), 0);
        @(posedge clk); #1;

        // ---- random ready/valid scoreboard ----
        for (int p = 0; p < 25; p++) begin
            fl_t x;
            int cid, len;
            cid = $urandom_range(0, 3);
            len = $urandom_range(0, 4);
            x.d = hf(cid, len, p); x.dest = cid; stim.push_back(x);
            for (int b = 0; b < len; b++) begin
                x.d = bf(p*8 + b); x.dest = cid; stim.push_back(x);
            end
        end
        cyc = 0;
        nflit = 0;
        while ((stim.size() > 0 || expq.size() > 0) && cyc < 3000) begin
            v4  = (stim.size() > 0) && ($urandom_range(0, 3) != 0);
            d4  = v4 ? stim[0].d : 16'h0;
            lr4 = 4'($urandom_range(0, 15));
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                if (lv4[d] && lr4[d]) begin
                    if (expq.size() == 0) begin
                        chk($sformatf("rand.extra_flit_out%0d", d), 1, 0);
                    end else begin
                        fl_t e;
                        e = expq.pop_front();
                        chk($sformatf("rand.flit%0d{dest,data}", nflit),
                            {16'(d), ld4[d*16 +: 16]}, {16'(e.dest), e.d});
                        nflit++;
                    end
                end
            end
            if (v4 && irdy4) expq.push_back(stim.pop_front());
            @(posedge clk); #1;
            cyc++;
        end
        v4 = 1'b0;
        chk("rand.all_delivered", 32'(stim.size() + expq.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
